// File: rtl/cevero_periph_resp.sv
// cevero_periph_resp: req/gnt/rvalid responder exposing ID, scratch, fault count, cycle count and DVFS voltage set.
module cevero_periph_resp #(
    parameter int          WaitStates = 0,
    parameter logic [3:0]  DefVoltage = 4'd8,
    parameter logic [31:0] IdValue    = 32'hCE0E_0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        error_i,
    output logic [3:0]  vset_o
);
    localparam logic [3:0] WS = 4'(WaitStates);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] scratch, errcnt, cyclecnt, rd;
    logic [7:0]  off;
    logic        bad, wr, clr;
    logic        unused_addr;
    assign unused_addr = ^addr_i[31:8];
    assign off   = addr_i[7:0];
    assign bad   = (addr_i[1:0] != 2'b00) || (off > 8'h10);
    assign gnt_o = req_i && (cnt == WS);
    assign wr    = gnt_o && we_i && !bad;
    assign clr   = wr && (off == 8'h08);
    always_comb begin
        rd = (off == 8'h00) ? IdValue :
             (off == 8'h04) ? scratch :
             (off == 8'h08) ? errcnt :
             (off == 8'h0C) ? cyclecnt :
             (off == 8'h10) ? {28'h0, vset_o} : 32'h0;
    end
    // grant FSM: cnt counts held request cycles; any grant or dropped request returns to IDLE
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (gnt_o || !req_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= WAIT;
            cnt   <= (state == IDLE) ? 4'd1 : cnt + 4'd1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scratch  <= 32'h0;
            errcnt   <= 32'h0;
            cyclecnt <= 32'h0;
            vset_o   <= DefVoltage;
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
            err_o    <= 1'b0;
        end else begin
            cyclecnt <= cyclecnt + 32'd1;
            rvalid_o <= gnt_o;
            rdata_o  <= (gnt_o && !we_i && !bad) ? rd : 32'h0;
            err_o    <= gnt_o && bad;
            // clear beats a simultaneous fault event; count saturates at all-ones
            errcnt   <= clr ? 32'h0 : (error_i && errcnt != 32'hFFFF_FFFF) ? errcnt + 32'd1 : errcnt;
            if (wr && off == 8'h04)
                for (int i = 0; i < 4; i++)
                    if (be_i[i]) scratch[8*i +: 8] <= wdata_i[8*i +: 8];
            if (wr && off == 8'h10 && be_i[0]) vset_o <= wdata_i[3:0];
        end
    end
endmodule
